ps2_scan_receiver: RTL and testbench
====================================

PS2_SCAN_RECEIVER -- requirements
Module: ps2_scan_receiver

Interface
REQ-001 Parameter TIMEOUT_CYC, default 50000, is the number of clk cycles without a ps2_clk falling edge after which a partial frame SHALL be abandoned.
REQ-002 clk  input  1  system clock; every flop SHALL be clocked on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-005 ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-006 last_change  output  9  most recent key code: bit 8 = E0-extended flag, bits 7:0 = scan code.
REQ-007 key_valid  output  1  single-cycle pulse; last_change and key_make are updated in the same cycle.
REQ-008 key_make  output  1  1 = make (press), 0 = break (release), for the current last_change.
REQ-009 frame_err  output  1  single-cycle pulse on a rejected frame (bad start, parity or stop bit).

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before use.
REQ-011 A falling edge SHALL be detected by comparing the synchronized ps2_clk with its value one cycle earlier; ps2_data SHALL be sampled only in that edge cycle.
REQ-012 Frame format: start(0), 8 data bits LSB first, odd parity, stop(1); 11 edges total, tracked by a 4-bit bit counter 0..10.
REQ-013 Receive FSM states: IDLE, RECV.
  - IDLE to RECV on an edge sampling 0.
  - An edge sampling 1 in IDLE SHALL be ignored with no frame_err.
REQ-014 Frame end: in RECV, the edge at bit count 10 SHALL return the FSM to IDLE.
  - Frame accepted only if the 8 data bits plus the parity bit contain an odd number of ones and the stop bit is 1.
  - Otherwise frame_err SHALL pulse.
REQ-015 Timeout counter: cleared on every edge; counts while in RECV.
  - On reaching TIMEOUT_CYC the FSM SHALL return to IDLE and discard the partial byte.
  - No frame_err, no key_valid.
REQ-016 Prefix handling on an accepted byte:
  - 0xE0 SHALL set ext.
  - 0xF0 SHALL set brk.
  - Neither prefix produces key_valid.
REQ-017 Any other accepted byte B SHALL produce, one cycle after the stop-bit edge cycle:
  - last_change = {ext, B}
  - key_make = ~brk
  - key_valid = 1
  - ext and brk cleared in that same cycle.
REQ-018 frame_err SHALL also clear ext and brk, so a corrupted sequence never applies a stale prefix.
REQ-019 last_change and key_make SHALL hold their values between key_valid pulses.
REQ-020 key_valid and frame_err SHALL never be asserted in the same cycle, and each SHALL be high for exactly one clk cycle per event.
REQ-021 Prefix order: E0 followed by F0 SHALL yield ext=1 and brk=1 for the next code byte; a repeated identical prefix SHALL leave the flag set.
REQ-022 Rate limit: the block SHALL accept back-to-back frames separated by at least one idle ps2_clk high period of 2 clk cycles or more.

Reset
REQ-023 While rst_n=0 the following SHALL be forced regardless of clk:
  - last_change=9'h000, key_valid=0, key_make=0, frame_err=0
  - FSM=IDLE, bit counter=0, timeout counter=0, ext=0, brk=0
  - synchronizer flops=1
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; the first frame fully received after release SHALL decode normally.

Verification
REQ-025 Frame 0x70 -> one key_valid pulse, last_change=9'h070, key_make=1.
REQ-026 Frames F0, 69 -> exactly one key_valid pulse, last_change=9'h069, key_make=0.
REQ-027 Frames E0, F0, 7A -> last_change=9'h17A, key_make=0; then frame 5A -> 9'h05A, key_make=1 (prefixes cleared).
REQ-028 Frame 0x72 with parity bit inverted -> frame_err one cycle, no key_valid, last_change unchanged; then E0 with bad stop, followed by 6B -> 9'h06B (ext cleared).
REQ-029 Five bits of a frame, then ps2_clk held high for TIMEOUT_CYC+10 cycles, then full frame 0x75 -> 9'h075, key_make=1, no frame_err.
REQ-030 rst_n pulsed low after bit 4 of a frame, then full frame 0x7D -> all outputs 0 during reset; after release one key_valid with last_change=9'h07D.

Source files
------------

// File: rtl/ps2_scan_receiver.sv
// ---------------------------------------------------------------------------
// ps2_scan_receiver
//
// Receives PS/2 keyboard frames and decodes scan-code set 2 make/break
// sequences into one registered key event per code byte.
//
// Parameters
//   TIMEOUT_CYC  clk cycles without a ps2_clk falling edge before a partial
//                frame is dropped.
//
// Ports
//   clk          system clock; all flops use its rising edge
//   rst_n        asynchronous active-low reset
//   ps2_clk      raw PS/2 clock line (asynchronous to clk)
//   ps2_data     raw PS/2 data line (asynchronous to clk)
//   last_change  {E0-extended flag, scan code} of the most recent key event
//   key_valid    one-cycle pulse when last_change / key_make are updated
//   key_make     1 = press, 0 = release, for the current last_change
//   frame_err    one-cycle pulse on a rejected frame (parity or stop bit)
// ---------------------------------------------------------------------------
module ps2_scan_receiver #(
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [8:0] last_change,
   output logic       key_valid,
   output logic       key_make,
   output logic       frame_err
);

   localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);
   localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
   localparam logic [TMO_W-1:0] TMO_ZERO = TMO_W'(0);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } state_t;

   // True when the data bits plus the parity bit hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [8:0] bits);
      return ^bits;
   endfunction

   // Synchronizer and edge-detect flops
   logic             clk_meta_r;
   logic             clk_sync_r;
   logic             clk_prev_r;
   logic             data_meta_r;
   logic             data_sync_r;
   logic             fall_s;

   // Receive FSM and datapath
   state_t           state_r;
   state_t           state_nxt_s;
   logic [3:0]       bit_cnt_r;
   logic [3:0]       bit_cnt_nxt_s;
   logic [8:0]       shift_r;
   logic [8:0]       shift_nxt_s;
   logic [TMO_W-1:0] tmo_cnt_r;
   logic [TMO_W-1:0] tmo_nxt_s;
   logic             byte_done_s;
   logic             byte_err_s;
   logic [7:0]       byte_s;

   // Prefix flags and registered outputs
   logic             ext_r;
   logic             ext_nxt_s;
   logic             brk_r;
   logic             brk_nxt_s;
   logic [8:0]       last_change_r;
   logic [8:0]       last_change_nxt_s;
   logic             key_make_r;
   logic             key_make_nxt_s;
   logic             key_valid_r;
   logic             key_valid_nxt_s;
   logic             frame_err_r;
   logic             frame_err_nxt_s;

   // Two-flop synchronizers for both PS/2 lines plus the previous clock sample.
   // The lines idle high, so the flops reset to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_meta_r  <= 1'b1;
         clk_sync_r  <= 1'b1;
         clk_prev_r  <= 1'b1;
         data_meta_r <= 1'b1;
         data_sync_r <= 1'b1;
      end else begin
         clk_meta_r  <= ps2_clk;
         clk_sync_r  <= clk_meta_r;
         clk_prev_r  <= clk_sync_r;
         data_meta_r <= ps2_data;
         data_sync_r <= data_meta_r;
      end
   end

   assign fall_s = clk_prev_r & ~clk_sync_r;
   assign byte_s = shift_r[7:0];

   // Receive FSM state and frame datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         bit_cnt_r <= 4'd0;
         shift_r   <= 9'h000;
         tmo_cnt_r <= TMO_ZERO;
      end else begin
         state_r   <= state_nxt_s;
         bit_cnt_r <= bit_cnt_nxt_s;
         shift_r   <= shift_nxt_s;
         tmo_cnt_r <= tmo_nxt_s;
      end
   end

   // Next-state logic: bit counting, shifting, frame checking and timeout.
   // Bit counts 1..9 shift in data and parity (LSB first), so at count 10
   // shift_r holds {parity, data} and the sampled line is the stop bit.
   always_comb begin
      state_nxt_s   = state_r;
      bit_cnt_nxt_s = bit_cnt_r;
      shift_nxt_s   = shift_r;
      tmo_nxt_s     = tmo_cnt_r;
      byte_done_s   = 1'b0;
      byte_err_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            tmo_nxt_s = TMO_ZERO;
            if (fall_s && !data_sync_r) begin
               state_nxt_s   = ST_RECV;
               bit_cnt_nxt_s = 4'd1;
               shift_nxt_s   = 9'h000;
            end else begin
               // A high sample here is line noise, not a start bit.
               bit_cnt_nxt_s = 4'd0;
            end
         end
         ST_RECV: begin
            if (fall_s) begin
               tmo_nxt_s = TMO_ZERO;
               if (bit_cnt_r == 4'd10) begin
                  state_nxt_s   = ST_IDLE;
                  bit_cnt_nxt_s = 4'd0;
                  if (odd_parity_ok(shift_r) && data_sync_r) begin
                     byte_done_s = 1'b1;
                  end else begin
                     byte_err_s = 1'b1;
                  end
               end else begin
                  shift_nxt_s   = {data_sync_r, shift_r[8:1]};
                  bit_cnt_nxt_s = bit_cnt_r + 4'd1;
               end
            end else if (tmo_cnt_r == TMO_MAX) begin
               // Device stopped clocking mid-frame: drop the partial byte.
               state_nxt_s   = ST_IDLE;
               bit_cnt_nxt_s = 4'd0;
               tmo_nxt_s     = TMO_ZERO;
            end else begin
               tmo_nxt_s = tmo_cnt_r + TMO_ONE;
            end
         end
         default: begin
            state_nxt_s   = ST_IDLE;
            bit_cnt_nxt_s = 4'd0;
            tmo_nxt_s     = TMO_ZERO;
         end
      endcase
   end

   // Scan-code decode: E0/F0 only arm flags; any other byte emits an event.
   // A rejected frame also drops any pending prefix.
   always_comb begin
      ext_nxt_s         = ext_r;
      brk_nxt_s         = brk_r;
      last_change_nxt_s = last_change_r;
      key_make_nxt_s    = key_make_r;
      key_valid_nxt_s   = 1'b0;
      frame_err_nxt_s   = 1'b0;
      if (byte_done_s) begin
         if (byte_s == 8'hE0) begin
            ext_nxt_s = 1'b1;
         end else if (byte_s == 8'hF0) begin
            brk_nxt_s = 1'b1;
         end else begin
            last_change_nxt_s = {ext_r, byte_s};
            key_make_nxt_s    = ~brk_r;
            key_valid_nxt_s   = 1'b1;
            ext_nxt_s         = 1'b0;
            brk_nxt_s         = 1'b0;
         end
      end else if (byte_err_s) begin
         frame_err_nxt_s = 1'b1;
         ext_nxt_s       = 1'b0;
         brk_nxt_s       = 1'b0;
      end else begin
         ext_nxt_s = ext_r;
         brk_nxt_s = brk_r;
      end
   end

   // Prefix flags and output registers; pulses last exactly one cycle
   // because their next values default to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_r         <= 1'b0;
         brk_r         <= 1'b0;
         last_change_r <= 9'h000;
         key_make_r    <= 1'b0;
         key_valid_r   <= 1'b0;
         frame_err_r   <= 1'b0;
      end else begin
         ext_r         <= ext_nxt_s;
         brk_r         <= brk_nxt_s;
         last_change_r <= last_change_nxt_s;
         key_make_r    <= key_make_nxt_s;
         key_valid_r   <= key_valid_nxt_s;
         frame_err_r   <= frame_err_nxt_s;
      end
   end

   assign last_change = last_change_r;
   assign key_make    = key_make_r;
   assign key_valid   = key_valid_r;
   assign frame_err   = frame_err_r;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// ---------------------------------------------------------------------------
// tb_ps2_scan_receiver
//
// Self-checking bench for ps2_scan_receiver. A table of frames is applied;
// expected key events are pushed to a scoreboard queue as each frame is
// sent, and a monitor pops and compares them when key_valid / frame_err
// pulse. Hand-written sequences cover timeout and mid-frame reset.
// ---------------------------------------------------------------------------
module tb_ps2_scan_receiver;

   localparam int TMO = 200;

   logic       clk;
   logic       rst_n;
   logic       ps2_clk;
   logic       ps2_data;
   logic [8:0] last_change;
   logic       key_valid;
   logic       key_make;
   logic       frame_err;

   ps2_scan_receiver #(.TIMEOUT_CYC(TMO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .last_change (last_change),
      .key_valid   (key_valid),
      .key_make    (key_make),
      .frame_err   (frame_err)
   );

   typedef struct {
      logic       v;
      logic       e;
      logic [8:0] lc;
      logic       mk;
   } exp_t;

   typedef struct {
      logic [7:0] b;
      logic       flip;
      logic       bad_stop;
      logic       exp_v;
      logic       exp_e;
      logic [8:0] exp_lc;
      logic       exp_mk;
   } vec_t;

   exp_t sb_q[$];
   exp_t mon_e;
   vec_t vecs[17];
   int   n_checks = 0;
   int   n_errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      repeat (3) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (6) @(posedge clk);
      #1 ps2_clk = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic flip, input logic bad_stop,
                             input int nbits);
      logic [10:0] bits;
      bits = {~bad_stop, (~^b) ^ flip, b, 1'b0};
      for (int i = 0; i < nbits; i++) send_bit(bits[i]);
      ps2_data = 1'b1;
   endtask

   task automatic push_exp(input logic v, input logic e, input logic [8:0] lc, input logic mk);
      exp_t x;
      x.v  = v;
      x.e  = e;
      x.lc = lc;
      x.mk = mk;
      sb_q.push_back(x);
   endtask

   // Checks that every expected event arrived and the outputs hold.
   task automatic drain_check(input string tag, input logic [8:0] lc, input logic mk);
      repeat (20) @(posedge clk);
      #1;
      check({tag, "_drain"}, 9'(sb_q.size()), 9'd0);
      check({tag, "_hold_lc"}, last_change, lc);
      check({tag, "_hold_mk"}, {8'd0, key_make}, {8'd0, mk});
      sb_q.delete();
   endtask

   // Monitor: compare each output pulse against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n) begin
         if (key_valid && frame_err) begin
            n_checks++;
            n_errors++;
            $display("FAIL both_pulses: key_valid=1 frame_err=1 required not both");
         end else if (key_valid || frame_err) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_event: key_valid=%b frame_err=%b lc=%h required none",
                        key_valid, frame_err, last_change);
            end else begin
               mon_e = sb_q.pop_front();
               check("event_kind", {7'd0, key_valid, frame_err}, {7'd0, mon_e.v, mon_e.e});
               check("event_lc", last_change, mon_e.lc);
               check("event_mk", {8'd0, key_make}, {8'd0, mon_e.mk});
            end
         end
      end
   end

   initial begin
      //          byte   flip  bstop v     e     lc       make
      vecs[0]  = '{8'h70, 1'b0, 1'b0, 1'b1, 1'b0, 9'h070, 1'b1};
      vecs[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h070, 1'b1};
      vecs[2]  = '{8'h69, 1'b0, 1'b0, 1'b1, 1'b0, 9'h069, 1'b0};
      vecs[3]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h069, 1'b0};
      vecs[4]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h069, 1'b0};
      vecs[5]  = '{8'h7A, 1'b0, 1'b0, 1'b1, 1'b0, 9'h17A, 1'b0};
      vecs[6]  = '{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 9'h05A, 1'b1};
      vecs[7]  = '{8'h72, 1'b1, 1'b0, 1'b0, 1'b1, 9'h05A, 1'b1};
      vecs[8]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b1, 9'h05A, 1'b1};
      vecs[9]  = '{8'h6B, 1'b0, 1'b0, 1'b1, 1'b0, 9'h06B, 1'b1};
      vecs[10] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h06B, 1'b1};
      vecs[11] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h06B, 1'b1};
      vecs[12] = '{8'h74, 1'b0, 1'b0, 1'b1, 1'b0, 9'h174, 1'b1};
      vecs[13] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h174, 1'b1};
      vecs[14] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h174, 1'b1};
      vecs[15] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h174, 1'b1};
      vecs[16] = '{8'h71, 1'b0, 1'b0, 1'b1, 1'b0, 9'h171, 1'b0};

      rst_n    = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("reset_lc", last_change, 9'h000);
      check("reset_flags", {6'd0, key_valid, key_make, frame_err}, 9'd0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      for (int i = 0; i < 17; i++) begin
         if (vecs[i].exp_v || vecs[i].exp_e)
            push_exp(vecs[i].exp_v, vecs[i].exp_e, vecs[i].exp_lc, vecs[i].exp_mk);
         send_frame(vecs[i].b, vecs[i].flip, vecs[i].bad_stop, 11);
         drain_check($sformatf("vec%0d", i), vecs[i].exp_lc, vecs[i].exp_mk);
      end

      // Partial frame abandoned by timeout, then a clean frame.
      send_frame(8'h33, 1'b0, 1'b0, 5);
      repeat (TMO + 10) @(posedge clk);
      #1;
      push_exp(1'b1, 1'b0, 9'h075, 1'b1);
      send_frame(8'h75, 1'b0, 1'b0, 11);
      drain_check("timeout", 9'h075, 1'b1);

      // Reset in the middle of a frame, then a clean frame.
      send_frame(8'h7D, 1'b0, 1'b0, 5);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("midreset_lc", last_change, 9'h000);
      check("midreset_flags", {6'd0, key_valid, key_make, frame_err}, 9'd0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      push_exp(1'b1, 1'b0, 9'h07D, 1'b1);
      send_frame(8'h7D, 1'b0, 1'b0, 11);
      drain_check("after_reset", 9'h07D, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
